// File: rtl/brisc_pkg.sv
// Shared core definitions: stage indices and pipeline controller state encoding.
package brisc_pkg;

  localparam int STG_F      = 0;
  localparam int STG_D      = 1;
  localparam int STG_E      = 2;
  localparam int STG_M      = 3;
  localparam int STG_WB     = 4;
  localparam int NUM_STAGES = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    IMISS    = 2'd1,
    DMISS    = 2'd2,
    MUL_WAIT = 2'd3
  } pctrl_state_e;

  typedef logic [NUM_STAGES-1:0] stage_mask_t;

  function automatic stage_mask_t stg_bit(input int idx);
    stage_mask_t m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // Stage-mask encodings used by the stall/flush sequencer.
  localparam stage_mask_t MASK_NONE = '0;
  localparam stage_mask_t MASK_ALL  = '1;
  localparam stage_mask_t EN_MUL    = stg_bit(STG_M) | stg_bit(STG_WB);
  localparam stage_mask_t EN_LU     = stg_bit(STG_E) | stg_bit(STG_M) | stg_bit(STG_WB);
  localparam stage_mask_t EN_IMISS  = MASK_ALL & ~stg_bit(STG_F);
  localparam stage_mask_t FL_TRAP   = MASK_ALL & ~stg_bit(STG_F);
  localparam stage_mask_t FL_DMISS  = stg_bit(STG_WB);
  localparam stage_mask_t FL_BRANCH = stg_bit(STG_D) | stg_bit(STG_E);
  localparam stage_mask_t FL_MUL    = stg_bit(STG_M);
  localparam stage_mask_t FL_LU     = stg_bit(STG_E);
  localparam stage_mask_t FL_IMISS  = stg_bit(STG_D);

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the D-stage sources and the E-stage load.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_reg_write,
  input  logic             i_ex_is_load,
  output logic             o_hazard
);

  logic w_ld_writes;
  logic w_match;

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign w_ld_writes = i_ex_is_load & i_ex_reg_write & (i_ex_rd != '0);
  assign w_match     = (i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                       (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd));
  assign o_hazard    = w_ld_writes & w_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: turns hazards, cache misses, multiply occupancy
// and traps into one enable/bubble decision per stage register each cycle.
module pipeline_ctrl
  import brisc_pkg::*;
#(
  parameter int MUL_LATENCY = 5,
  parameter int REG_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_is_load,
  input  logic             ex_is_mul,
  input  logic             ex_branch_taken,
  input  logic             icache_miss,
  input  logic             icache_ready,
  input  logic             dcache_miss,
  input  logic             dcache_ready,
  input  logic             exc_valid,
  output logic [4:0]       stage_en,
  output logic [4:0]       stage_flush,
  output logic             pc_trap_sel,
  output logic             stall
);

  localparam bit         MUL_STALLS = (MUL_LATENCY > 1);
  localparam logic [3:0] MUL_INIT   = MUL_STALLS ? 4'(MUL_LATENCY - 2) : 4'd0;

  pctrl_state_e r_state;
  logic [3:0]   r_mul_cnt;
  logic         r_imiss_pending;
  logic         r_ifill_done;

  pctrl_state_e w_state_nxt;
  logic [3:0]   w_mul_cnt_nxt;
  logic         w_imiss_pending_nxt;
  logic         w_ifill_done_nxt;
  stage_mask_t  w_en;
  stage_mask_t  w_flush;
  logic         w_trap;
  logic         w_load_use;

  load_use_detect #(
    .REG_W(REG_W)
  ) u_load_use (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_reg_write(ex_reg_write),
    .i_ex_is_load  (ex_is_load),
    .o_hazard      (w_load_use)
  );

  always_comb begin
    w_en                = MASK_ALL;
    w_flush             = MASK_NONE;
    w_trap              = 1'b0;
    w_state_nxt         = r_state;
    w_mul_cnt_nxt       = r_mul_cnt;
    w_imiss_pending_nxt = r_imiss_pending;
    w_ifill_done_nxt    = r_ifill_done;

    if (reset) begin
      w_en    = MASK_NONE;
      w_flush = MASK_ALL;
    end else if (exc_valid) begin
      w_flush             = FL_TRAP;
      w_trap              = 1'b1;
      w_state_nxt         = RUN;
      w_mul_cnt_nxt       = 4'd0;
      w_imiss_pending_nxt = 1'b0;
      w_ifill_done_nxt    = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (dcache_miss) begin
            // A mul stuck behind the miss simply re-enters from RUN afterwards.
            w_en        = MASK_NONE;
            w_flush     = FL_DMISS;
            w_state_nxt = DMISS;
            if (icache_miss) w_imiss_pending_nxt = 1'b1;
          end else if (ex_branch_taken) begin
            w_flush = FL_BRANCH;
          end else if (ex_is_mul && MUL_STALLS) begin
            w_en          = EN_MUL;
            w_flush       = FL_MUL;
            w_mul_cnt_nxt = MUL_INIT;
            w_state_nxt   = MUL_WAIT;
          end else if (w_load_use) begin
            w_en    = EN_LU;
            w_flush = FL_LU;
          end else if (icache_miss) begin
            w_en        = EN_IMISS;
            w_flush     = FL_IMISS;
            w_state_nxt = IMISS;
          end
        end

        IMISS: begin
          if (ex_branch_taken) begin
            w_flush = FL_BRANCH;
          end else begin
            w_en    = EN_IMISS;
            w_flush = FL_IMISS;
          end
          // If the fetch fill lands in the same cycle, nothing is left to wait for.
          if (dcache_miss) begin
            w_state_nxt         = DMISS;
            w_imiss_pending_nxt = ~icache_ready;
          end else if (icache_ready) begin
            w_state_nxt = RUN;
          end
        end

        DMISS: begin
          w_en    = MASK_NONE;
          w_flush = FL_DMISS;
          if (icache_ready) w_ifill_done_nxt = 1'b1;
          if (dcache_ready) begin
            w_state_nxt = (r_imiss_pending && !(r_ifill_done || icache_ready)) ? IMISS : RUN;
            w_imiss_pending_nxt = 1'b0;
            w_ifill_done_nxt    = 1'b0;
          end
        end

        MUL_WAIT: begin
          if (r_mul_cnt != 4'd0) begin
            w_en          = EN_MUL;
            w_flush       = FL_MUL;
            w_mul_cnt_nxt = r_mul_cnt - 4'd1;
          end else begin
            w_state_nxt = RUN;
          end
        end

        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= RUN;
      r_mul_cnt       <= 4'd0;
      r_imiss_pending <= 1'b0;
      r_ifill_done    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_mul_cnt       <= w_mul_cnt_nxt;
      r_imiss_pending <= w_imiss_pending_nxt;
      r_ifill_done    <= w_ifill_done_nxt;
    end
  end

  assign stage_en    = w_en;
  assign stage_flush = w_flush;
  assign pc_trap_sel = w_trap;
  assign stall       = ~&w_en;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed cycles push expected controls, a monitor checks them.
module tb_pipeline_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_reg_write, ex_is_load, ex_is_mul, ex_branch_taken;
  logic       icache_miss, icache_ready, dcache_miss, dcache_ready, exc_valid;
  logic [4:0] stage_en, stage_flush;
  logic       pc_trap_sel, stall;

  typedef struct {
    logic [4:0] en;
    logic [4:0] fl;
    logic       tr;
    logic       st;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  pipeline_ctrl #(.MUL_LATENCY(5), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_is_mul(ex_is_mul), .ex_branch_taken(ex_branch_taken),
    .icache_miss(icache_miss), .icache_ready(icache_ready),
    .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
    .exc_valid(exc_valid),
    .stage_en(stage_en), .stage_flush(stage_flush),
    .pc_trap_sel(pc_trap_sel), .stall(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (stage_en !== e.en || stage_flush !== e.fl || pc_trap_sel !== e.tr || stall !== e.st) begin
        bad++;
        $display("FAIL %s: got en=%b flush=%b trap=%b stall=%b, want en=%b flush=%b trap=%b stall=%b",
                 e.nm, stage_en, stage_flush, pc_trap_sel, stall, e.en, e.fl, e.tr, e.st);
      end
    end
  end

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_reg_write = 1'b0; ex_is_load = 1'b0; ex_is_mul = 1'b0; ex_branch_taken = 1'b0;
    icache_miss = 1'b0; icache_ready = 1'b0; dcache_miss = 1'b0; dcache_ready = 1'b0;
    exc_valid = 1'b0;
  endtask

  // Inputs for the cycle are already driven; queue the expected controls and advance.
  task automatic step(input logic [4:0] en, input logic [4:0] fl, input logic tr, input string nm);
    exp_t e;
    e.en = en; e.fl = fl; e.tr = tr; e.st = (en != 5'b11111); e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
    id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;

    step(5'b00000, 5'b11111, 1'b0, "reset_a");
    step(5'b00000, 5'b11111, 1'b0, "reset_b");
    reset = 1'b0;
    step(5'b11111, 5'b00000, 1'b0, "run_idle");

    // Load-use: exactly one bubble, none for x0 or non-writing loads.
    set_load_use(5'd5);
    step(5'b11100, 5'b00100, 1'b0, "lu_bubble");
    idle();
    step(5'b11111, 5'b00000, 1'b0, "lu_once");
    set_load_use(5'd0);
    step(5'b11111, 5'b00000, 1'b0, "lu_rd0");
    set_load_use(5'd7); id_rs1 = 5'd7; id_uses_rs1 = 1'b1; ex_reg_write = 1'b0;
    step(5'b11111, 5'b00000, 1'b0, "lu_nowrite");
    set_load_use(5'd5); ex_branch_taken = 1'b1;
    step(5'b11111, 5'b00110, 1'b0, "lu_branch");
    idle();

    // Multiply: 4 hold cycles then release; ex_is_mul on release is ignored.
    ex_is_mul = 1'b1;
    step(5'b11000, 5'b01000, 1'b0, "mul_entry");
    ex_is_mul = 1'b0;
    step(5'b11000, 5'b01000, 1'b0, "mul_hold1");
    step(5'b11000, 5'b01000, 1'b0, "mul_hold2");
    step(5'b11000, 5'b01000, 1'b0, "mul_hold3");
    ex_is_mul = 1'b1;
    step(5'b11111, 5'b00000, 1'b0, "mul_release");
    ex_is_mul = 1'b0;
    step(5'b11111, 5'b00000, 1'b0, "mul_back_run");

    // D+I miss, no fetch fill during DMISS -> IMISS afterwards.
    dcache_miss = 1'b1; icache_miss = 1'b1;
    step(5'b00000, 5'b10000, 1'b0, "dmiss_entry");
    idle();
    for (int i = 0; i < 4; i++) step(5'b00000, 5'b10000, 1'b0, "dmiss_hold");
    dcache_ready = 1'b1;
    step(5'b00000, 5'b10000, 1'b0, "dmiss_ready");
    idle();
    step(5'b11110, 5'b00010, 1'b0, "imiss_after_d");
    step(5'b11110, 5'b00010, 1'b0, "imiss_wait");
    icache_ready = 1'b1;
    step(5'b11110, 5'b00010, 1'b0, "imiss_ready");
    idle();
    step(5'b11111, 5'b00000, 1'b0, "imiss_to_run");

    // D+I miss with fetch fill during DMISS -> straight to RUN.
    dcache_miss = 1'b1; icache_miss = 1'b1;
    step(5'b00000, 5'b10000, 1'b0, "dmiss2_entry");
    idle();
    step(5'b00000, 5'b10000, 1'b0, "dmiss2_hold");
    icache_ready = 1'b1;
    step(5'b00000, 5'b10000, 1'b0, "dmiss2_ifill");
    idle();
    step(5'b00000, 5'b10000, 1'b0, "dmiss2_hold");
    step(5'b00000, 5'b10000, 1'b0, "dmiss2_hold");
    dcache_ready = 1'b1;
    step(5'b00000, 5'b10000, 1'b0, "dmiss2_ready");
    idle();
    step(5'b11111, 5'b00000, 1'b0, "dmiss2_to_run");

    // Trap during MUL_WAIT with mul_cnt=2.
    ex_is_mul = 1'b1;
    step(5'b11000, 5'b01000, 1'b0, "mulx_entry");
    ex_is_mul = 1'b0;
    step(5'b11000, 5'b01000, 1'b0, "mulx_hold");
    exc_valid = 1'b1;
    step(5'b11111, 5'b11110, 1'b1, "exc_trap");
    idle();
    step(5'b11111, 5'b00000, 1'b0, "exc_run");
    step(5'b11111, 5'b00000, 1'b0, "exc_run2");

    // Reset in the middle of DMISS.
    dcache_miss = 1'b1;
    step(5'b00000, 5'b10000, 1'b0, "rst_dmiss_entry");
    idle();
    step(5'b00000, 5'b10000, 1'b0, "rst_dmiss_hold");
    reset = 1'b1;
    step(5'b00000, 5'b11111, 1'b0, "rst_mid_a");
    step(5'b00000, 5'b11111, 1'b0, "rst_mid_b");
    reset = 1'b0;
    step(5'b11111, 5'b00000, 1'b0, "rst_release");

    // Plain IMISS, branch inside IMISS, stray fills ignored in RUN.
    icache_miss = 1'b1;
    step(5'b11110, 5'b00010, 1'b0, "imiss_entry");
    icache_miss = 1'b0; ex_branch_taken = 1'b1;
    step(5'b11111, 5'b00110, 1'b0, "imiss_branch");
    ex_branch_taken = 1'b0;
    step(5'b11110, 5'b00010, 1'b0, "imiss_still");
    icache_ready = 1'b1;
    step(5'b11110, 5'b00010, 1'b0, "imiss_fill");
    icache_ready = 1'b0; dcache_ready = 1'b1;
    step(5'b11111, 5'b00000, 1'b0, "stray_dready");
    idle();
    step(5'b11111, 5'b00000, 1'b0, "stray_after");

    // dcache miss arriving in IMISS: DMISS, then back to IMISS.
    icache_miss = 1'b1;
    step(5'b11110, 5'b00010, 1'b0, "id_imiss_entry");
    icache_miss = 1'b0; dcache_miss = 1'b1;
    step(5'b11110, 5'b00010, 1'b0, "id_dmiss_in_imiss");
    dcache_miss = 1'b0;
    step(5'b00000, 5'b10000, 1'b0, "id_dmiss_hold");
    dcache_ready = 1'b1;
    step(5'b00000, 5'b10000, 1'b0, "id_dmiss_ready");
    idle();
    step(5'b11110, 5'b00010, 1'b0, "id_back_imiss");
    icache_ready = 1'b1;
    step(5'b11110, 5'b00010, 1'b0, "id_ifill");
    idle();
    exc_valid = 1'b1;
    step(5'b11111, 5'b11110, 1'b1, "exc_in_run");
    idle();
    step(5'b11111, 5'b00000, 1'b0, "final_run");

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage core.
- Drives the `enable` and synchronous `reset` inputs of every inter-stage `ff`/`nff` register (F = PC, D = IF/ID, E = ID/EX, M = EX/MEM, WB = MEM/WB).
- Resolves load-use hazards, taken branches, multi-cycle multiply occupancy, I-/D-cache miss stalls and WB-stage exceptions into one per-stage hold/bubble decision each cycle.
- Sits beside the datapath. The cache handshakes and the multiplier latency are sequenced here, so no stage register ever sees conflicting controls.

## Interface
- MUL_LATENCY, default 5: cycles a MUL occupies E. Range 1..15; 1 means no stall.
- REG_W, default 5: register-index width.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_rs1, id_rs2  in  REG_W  D-stage source indices
- id_uses_rs1, id_uses_rs2  in  1  source actually read
- ex_rd  in  REG_W  E-stage destination
- ex_reg_write, ex_is_load, ex_is_mul  in  1  E-stage instruction class
- ex_branch_taken  in  1  E-stage branch/jump redirects
- icache_miss, icache_ready  in  1  fetch miss / fill-done pulse
- dcache_miss, dcache_ready  in  1  M-stage miss / fill-done pulse
- exc_valid  in  1  WB-stage instruction traps
- stage_en  out  5  per-register enable, bit 0 = F … bit 4 = WB
- stage_flush  out  5  per-register sync reset (bubble); dominates enable
- pc_trap_sel  out  1  PC mux selects trap vector
- stall  out  1  any stage_en bit low (perf counter)

## Operation
- States: RUN, IMISS, DMISS, MUL_WAIT. Registered: state, 4-bit mul_cnt, imiss_pending, ifill_done.
- Outputs are combinational from state and inputs.
- Load-use hazard is true when all of these hold:
  - ex_is_load & ex_reg_write & ex_rd≠0
  - (id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)
- Default (RUN, no event): en=11111, flush=00000.
- Priority each cycle, highest first:
  1. exc_valid: flush=11110, en=11111, pc_trap_sel=1. Next state RUN; mul_cnt, imiss_pending and ifill_done clear.
  2. RUN & dcache_miss: en=00000, flush=10000. Next state DMISS. If icache_miss is also high, set imiss_pending.
  3. ex_branch_taken (RUN or IMISS): flush=00110, en=11111. Branch overrides load-use; the dependent instruction is wrong-path.
  4. RUN & ex_is_mul & MUL_LATENCY>1: en=11000, flush=01000. mul_cnt←MUL_LATENCY−2. Next state MUL_WAIT.
  5. RUN & load-use: en=11100, flush=00100. One bubble, stay RUN.
  6. RUN & icache_miss: en=11110, flush=00010. Next state IMISS.
- DMISS:
  - Outputs en=00000, flush=10000.
  - icache_ready seen in DMISS sets ifill_done.
  - On dcache_ready: next state IMISS if imiss_pending & !ifill_done, else RUN. Clear both flags.
  - exc_valid cannot occur in DMISS, because WB holds a bubble.
- IMISS:
  - Outputs en=11110, flush=00010, subject to rows 1 and 3 above.
  - dcache_miss in IMISS: next state DMISS, set imiss_pending.
  - icache_ready: next state RUN.
- MUL_WAIT:
  - If mul_cnt≠0: en=11000, flush=01000, mul_cnt−1.
  - If mul_cnt==0: release. en=11111, flush=00000, next state RUN. ex_is_mul is ignored this cycle.
- reset: state RUN, mul_cnt=0, flags=0. While reset is high, outputs are en=00000, flush=11111, pc_trap_sel=0, stall=1.

## Timing
- All state updates on posedge clk; reset has priority over every input.
- Load-use costs exactly 1 bubble.
- MUL holds E for exactly MUL_LATENCY cycles, including the entry cycle.
- DMISS releases the cycle after the dcache_ready pulse; the cache must hit on that retry.
- icache_ready or dcache_ready arriving in RUN or MUL_WAIT is ignored.
- dcache_miss and ex_is_mul in the same cycle: DMISS wins; the mul stays in E and is reissued from RUN afterwards.

## Structure
- brisc_pkg additions:
  - localparams STG_F=0 … STG_WB=4, NUM_STAGES=5
  - typedef enum logic [1:0] pctrl_state_e {RUN, IMISS, DMISS, MUL_WAIT}
- One combinational sub-module, load_use_detect, implements the load-use equation. It is reused by the forwarding unit.

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → exactly one cycle en=11100, flush=00100. Same case with ex_rd=0 → no stall.
- MUL_LATENCY=5: ex_is_mul pulse → en=11000, flush=01000 for 4 cycles, then one release cycle en=11111; state returns to RUN.
- Simultaneous dcache_miss and icache_miss, dcache_ready after 6 cycles, no icache_ready → 6 cycles en=00000, then IMISS (en=11110) until icache_ready.
- Same as previous case, but icache_ready arrives during DMISS → goes straight to RUN after dcache_ready.
- exc_valid during MUL_WAIT with mul_cnt=2 → flush=11110, pc_trap_sel=1; next cycle RUN, mul_cnt=0.
- reset asserted mid-DMISS → outputs en=00000, flush=11111 while high; first cycle after reset deasserts shows en=11111 with state RUN.
